// File: rtl/snake_grid_engine.sv
// Snake game engine on a GRID_W x GRID_H cell grid.
// The body lives in a circular buffer (head/tail pointers + length), mirrored
// by a one-bit-per-cell occupancy bitmap used for collision lookup and for the
// display query port.
// Build option: define SNAKE_WRAP_EN so the head wraps to the opposite edge
// instead of dying on a wall.
//
// state  | meaning
// CLEAR  | zero one bitmap cell per cycle (down-counter to 0)
// SEED   | write the initial body, tail first, heading right
// IDLE   | wait for a step tick
// LOOKUP | read the bitmap at the next head cell
// UPDATE | resolve collision, push head / pop tail, grow on food
// DEAD   | frozen until restart or reset
module snake_grid_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 4,
  parameter int INIT_X   = 20,
  parameter int INIT_Y   = 15,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          restart,
  input  logic          step,
  input  logic          dir_valid,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  output logic          q_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          ate,
  output logic          game_over,
  output logic          busy
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW = $clog2(CELLS);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
`ifdef SNAKE_WRAP_EN
  localparam logic WALL_KILLS = 1'b0;
`else
  localparam logic WALL_KILLS = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_CLEAR, S_SEED, S_IDLE, S_LOOKUP, S_UPDATE, S_DEAD
  } state_t;

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] head_x_q, head_x_d, nh_x_q, nh_x_d;
  logic [YW-1:0] head_y_q, head_y_d, nh_y_q, nh_y_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] hp_q, hp_d, tp_q, tp_d;
  logic [1:0]    heading_q, heading_d, pend_q, pend_d;
  logic          oob_q, oob_d, rd_hit_q, rd_hit_d, q_hit_q, q_hit_d, ate_q, ate_d;

  logic [CELLS-1:0] occ_mem;
  logic [XW-1:0]    body_x_mem [MAX_LEN];
  logic [YW-1:0]    body_y_mem [MAX_LEN];

  logic          occ_we, occ_wval, occ_clr, body_we;
  logic [AW-1:0] occ_waddr, occ_caddr;
  logic [PW-1:0] body_widx;
  logic [XW-1:0] body_wx, seed_x, step_x;
  logic [YW-1:0] body_wy, step_y;
  logic [PW-1:0] seed_idx;
  logic          at_edge;
  logic          food_hit, grow, hit_tail, collide;

  assign seed_x   = XW'(INIT_X) - XW'(cnt_q);
  assign seed_idx = PW'(INIT_LEN - 1) - PW'(cnt_q);
  assign food_hit = (nh_x_q == food_x) && (nh_y_q == food_y);
  assign grow     = food_hit && (len_q < LEN_MAX);
  assign hit_tail = (nh_x_q == body_x_mem[tp_q]) && (nh_y_q == body_y_mem[tp_q]);
  assign collide  = oob_q || (rd_hit_q && !(hit_tail && !grow));

  // Candidate next head from the pending direction; edges wrap, at_edge flags it.
  always_comb begin
    step_x  = head_x_q;
    step_y  = head_y_q;
    at_edge = 1'b0;
    case (pend_q)
      2'b00: begin at_edge = (head_x_q == X_MAX); step_x = at_edge ? '0 : head_x_q + XW'(1); end
      2'b01: begin at_edge = (head_x_q == '0); step_x = at_edge ? X_MAX : head_x_q - XW'(1); end
      2'b10: begin at_edge = (head_y_q == '0); step_y = at_edge ? Y_MAX : head_y_q - YW'(1); end
      default: begin at_edge = (head_y_q == Y_MAX); step_y = at_edge ? '0 : head_y_q + YW'(1); end
    endcase
  end

  // Next-state, datapath updates and memory write controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    head_x_d  = head_x_q;
    head_y_d  = head_y_q;
    nh_x_d    = nh_x_q;
    nh_y_d    = nh_y_q;
    len_d     = len_q;
    hp_d      = hp_q;
    tp_d      = tp_q;
    heading_d = heading_q;
    pend_d    = pend_q;
    oob_d     = oob_q;
    rd_hit_d  = rd_hit_q;
    ate_d     = 1'b0;
    occ_we    = 1'b0;
    occ_wval  = 1'b0;
    occ_waddr = '0;
    occ_clr   = 1'b0;
    occ_caddr = '0;
    body_we   = 1'b0;
    body_widx = '0;
    body_wx   = '0;
    body_wy   = '0;
    case (state_q)
      S_CLEAR: begin
        occ_we    = 1'b1;
        occ_waddr = cnt_q;
        if (cnt_q == '0) begin
          state_d = S_SEED;
          cnt_d   = AW'(INIT_LEN - 1);
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      S_SEED: begin
        occ_we    = 1'b1;
        occ_wval  = 1'b1;
        occ_waddr = cell_addr(seed_x, YW'(INIT_Y));
        body_we   = 1'b1;
        body_widx = seed_idx;
        body_wx   = seed_x;
        body_wy   = YW'(INIT_Y);
        head_x_d  = seed_x;
        head_y_d  = YW'(INIT_Y);
        hp_d      = seed_idx;
        len_d     = len_q + LW'(1);
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - AW'(1);
      end
      S_IDLE: begin
        if (step) begin
          heading_d = pend_q;
          nh_x_d    = step_x;
          nh_y_d    = step_y;
          oob_d     = at_edge && WALL_KILLS;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        rd_hit_d = occ_mem[cell_addr(nh_x_q, nh_y_q)];
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        if (collide) begin
          state_d = S_DEAD;
        end else begin
          state_d   = S_IDLE;
          hp_d      = ptr_inc(hp_q);
          body_we   = 1'b1;
          body_widx = ptr_inc(hp_q);
          body_wx   = nh_x_q;
          body_wy   = nh_y_q;
          occ_we    = 1'b1;
          occ_wval  = 1'b1;
          occ_waddr = cell_addr(nh_x_q, nh_y_q);
          head_x_d  = nh_x_q;
          head_y_d  = nh_y_q;
          ate_d     = food_hit;
          if (grow) begin
            len_d = len_q + LW'(1);
          end else begin
            tp_d      = ptr_inc(tp_q);
            occ_clr   = 1'b1;
            occ_caddr = cell_addr(body_x_mem[tp_q], body_y_mem[tp_q]);
          end
        end
      end
      S_DEAD: ;
      default: begin
        state_d = S_CLEAR;
        cnt_d   = AW'(CELLS - 1);
      end
    endcase
    // Reversal requests are judged against the heading actually in use.
    if (dir_valid && (dir != {heading_q[1], ~heading_q[0]})) pend_d = dir;
    if (restart) begin
      state_d   = S_CLEAR;
      cnt_d     = AW'(CELLS - 1);
      head_x_d  = XW'(INIT_X);
      head_y_d  = YW'(INIT_Y);
      len_d     = '0;
      hp_d      = '0;
      tp_d      = '0;
      heading_d = 2'b00;
      pend_d    = 2'b00;
      oob_d     = 1'b0;
      rd_hit_d  = 1'b0;
      ate_d     = 1'b0;
      occ_we    = 1'b0;
      occ_clr   = 1'b0;
      body_we   = 1'b0;
    end
    q_hit_d = !(state_d inside {S_CLEAR, S_SEED}) && (qx <= X_MAX) && (qy <= Y_MAX)
              && occ_mem[cell_addr(qx, qy)];
  end

  // Control and datapath registers with asynchronous reset into CLEAR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_CLEAR;
      cnt_q     <= AW'(CELLS - 1);
      head_x_q  <= XW'(INIT_X);
      head_y_q  <= YW'(INIT_Y);
      nh_x_q    <= '0;
      nh_y_q    <= '0;
      len_q     <= '0;
      hp_q      <= '0;
      tp_q      <= '0;
      heading_q <= 2'b00;
      pend_q    <= 2'b00;
      oob_q     <= 1'b0;
      rd_hit_q  <= 1'b0;
      q_hit_q   <= 1'b0;
      ate_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      head_x_q  <= head_x_d;
      head_y_q  <= head_y_d;
      nh_x_q    <= nh_x_d;
      nh_y_q    <= nh_y_d;
      len_q     <= len_d;
      hp_q      <= hp_d;
      tp_q      <= tp_d;
      heading_q <= heading_d;
      pend_q    <= pend_d;
      oob_q     <= oob_d;
      rd_hit_q  <= rd_hit_d;
      q_hit_q   <= q_hit_d;
      ate_q     <= ate_d;
    end
  end

  // Bitmap and body buffer; the head set is issued last so it beats a tail clear of the same cell.
  always_ff @(posedge clk) begin
    if (occ_clr) occ_mem[occ_caddr] <= 1'b0;
    if (occ_we) occ_mem[occ_waddr] <= occ_wval;
    if (body_we) begin
      body_x_mem[body_widx] <= body_wx;
      body_y_mem[body_widx] <= body_wy;
    end
  end

  assign q_hit     = q_hit_q;
  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = len_q;
  assign ate       = ate_q;
  assign game_over = (state_q == S_DEAD);
  assign busy      = (state_q inside {S_CLEAR, S_SEED, S_LOOKUP, S_UPDATE});

endmodule

// File: tb/tb_snake_grid_engine.sv
// Scoreboard bench for snake_grid_engine: a list-based reference snake predicts
// head, length, ate and game_over for every init and step.
module tb_snake_grid_engine;
  localparam int GW = 40, GH = 30, ML = 64, IL = 4, IX = 20, IY = 15;
  localparam int XW = $clog2(GW), YW = $clog2(GH), LW = $clog2(ML + 1);
  localparam int CELLS = GW * GH;

  logic clk = 1'b0;
  logic rstn, restart, step, dir_valid;
  logic [1:0] dir;
  logic [XW-1:0] food_x, qx, head_x;
  logic [YW-1:0] food_y, qy, head_y;
  logic [LW-1:0] length;
  logic q_hit, ate, game_over, busy;

  snake_grid_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL),
                      .INIT_X(IX), .INIT_Y(IY)) dut (
    .clk(clk), .rstn(rstn), .restart(restart), .step(step), .dir_valid(dir_valid),
    .dir(dir), .food_x(food_x), .food_y(food_y), .qx(qx), .qy(qy), .q_hit(q_hit),
    .head_x(head_x), .head_y(head_y), .length(length), .ate(ate),
    .game_over(game_over), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {int hx; int hy; int len; int ate; int go;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  int mx[$], my[$];
  int m_heading, m_pend;
  bit m_dead;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_occ(input int x, input int y);
    for (int i = 0; i < mx.size(); i++) if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_init();
    mx.delete(); my.delete();
    for (int k = IL - 1; k >= 0; k--) begin mx.push_back(IX - k); my.push_back(IY); end
    m_heading = 0; m_pend = 0; m_dead = 0;
  endtask

  function automatic exp_t m_snap(input int a);
    exp_t e;
    e.hx = mx[mx.size()-1]; e.hy = my[my.size()-1]; e.len = mx.size(); e.ate = a; e.go = m_dead;
    return e;
  endfunction

  task automatic compare_top(input string tag, input int ate_cnt);
    exp_t e;
    e = sb.pop_front();
    check({tag, ".head_x"}, head_x, e.hx);
    check({tag, ".head_y"}, head_y, e.hy);
    check({tag, ".length"}, length, e.len);
    check({tag, ".game_over"}, game_over, e.go);
    check({tag, ".ate_pulses"}, ate_cnt, e.ate);
  endtask

  task automatic wait_init(input int exp_n);
    int n, qv;
    n = 0; qv = 0; qx = IX; qy = IY;
    while (n < 3000) begin
      @(posedge clk); n++; #1;
      if (!busy) break;
      if (q_hit) qv++;
    end
    check("init_cycles", n, exp_n);
    check("q_hit_during_init", qv, 0);
    sb.push_back(m_snap(0));
    compare_top("init", 0);
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    m_init();
  endtask

  task automatic send_dir(input int d);
    if (d != (m_heading ^ 1)) m_pend = d;
    @(negedge clk); dir_valid = 1'b1; dir = 2'(d);
    @(negedge clk); dir_valid = 1'b0;
  endtask

  task automatic do_step(input string tag);
    int nx, ny, a, ac;
    bit oob, hit, fd, grow;
    a = 0;
    if (!m_dead) begin
      m_heading = m_pend;
      nx = mx[mx.size()-1]; ny = my[my.size()-1];
      case (m_heading)
        0: nx++;
        1: nx--;
        2: ny--;
        default: ny++;
      endcase
      oob = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
      nx = (nx + GW) % GW; ny = (ny + GH) % GH; oob = 0;
`endif
      fd = (nx == int'(food_x)) && (ny == int'(food_y));
      grow = fd && (mx.size() < ML);
      hit = 0;
      for (int i = (grow ? 0 : 1); i < mx.size(); i++) if (mx[i] == nx && my[i] == ny) hit = 1;
      if (oob || hit) m_dead = 1;
      else begin
        mx.push_back(nx); my.push_back(ny);
        if (!grow) begin void'(mx.pop_front()); void'(my.pop_front()); end
        a = fd;
      end
    end
    sb.push_back(m_snap(a));
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    ac = 0;
    repeat (6) begin @(negedge clk); if (ate) ac++; end
    check({tag, ".busy_after"}, busy, 0);
    compare_top(tag, ac);
  endtask

  task automatic query(input int x, input int y);
    @(negedge clk); qx = XW'(x); qy = YW'(y);
    @(negedge clk);
    check($sformatf("q_hit(%0d,%0d)", x, y), q_hit, m_occ(x, y));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1; restart = 1'b0; step = 1'b0; dir_valid = 1'b0; dir = 2'b00;
    food_x = '0; food_y = '0; qx = XW'(IX); qy = YW'(IY);
    #2 rstn = 1'b0;
    #1;
    check("rst.busy", busy, 1);
    check("rst.q_hit", q_hit, 0);
    check("rst.ate", ate, 0);
    check("rst.game_over", game_over, 0);
    check("rst.length", length, 0);
    check("rst.head_x", head_x, IX);
    check("rst.head_y", head_y, IY);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    m_init();
    wait_init(CELLS + IL);
    query(17, 15); query(16, 15); query(20, 15);

    // growth on food directly ahead
    food_x = XW'(21); food_y = YW'(15);
    do_step("eat");
    query(17, 15); query(21, 15);

    // reverse request is dropped
    do_restart(); wait_init(CELLS + IL);
    food_x = '0; food_y = '0;
    send_dir(1);
    do_step("reverse_rejected");

    // turn up, tail cell released
    do_restart(); wait_init(CELLS + IL);
    send_dir(2); do_step("up");
    query(17, 15); query(18, 15);
    // loop into own tail cell
    send_dir(1); do_step("left");
    send_dir(3); do_step("into_tail");
    query(19, 15); query(20, 15); query(18, 15);

    // length 5 turning back into its body
    do_restart(); wait_init(CELLS + IL);
    food_x = XW'(21); food_y = YW'(15);
    do_step("grow5");
    food_x = '0; food_y = '0;
    send_dir(2); do_step("b_up");
    send_dir(1); do_step("b_left");
    send_dir(3); do_step("b_down_collide");
    do_step("dead_ignores_step");

    // restart aborts a move in LOOKUP; steps during CLEAR are dropped
    do_restart(); wait_init(CELLS + IL);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; restart = 1'b1;
    check("busy_in_lookup", busy, 1);
    @(negedge clk); restart = 1'b0; step = 1'b1;
    @(negedge clk); step = 1'b0;
    check("busy_in_clear", busy, 1);
    m_init();
    wait_init(CELLS + IL - 1);

    // run to the right wall
    for (int i = 0; i < 19; i++) do_step($sformatf("run%0d", i));
    do_step("wall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
